polyphase_decim_fir: RTL and testbench

Parametrised decimating FIR for the Rx decimation chain. It accepts a valid-qualified signed sample stream and keeps every D-th filtered result, computing only at those instants. It supersedes the fixed 4-tap, decimate-by-2 comb stage with configurable tap count, factor, widths and coefficients. It adds input/output handshaking, a synchronous flush and optional round/saturate.

---
 rtl/polyphase_decim_fir.sv | 138 +++++++++++++
 tb/tb_polyphase_decim_fir.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_decim_fir.sv
// Decimating FIR: keeps every D-th filtered sample through a 3-stage shift/multiply/sum pipeline.
// Define ROUND_SAT_EN for round-half-up plus saturation; otherwise floor shift and two's-complement wrap.
module polyphase_decim_fir #(
    parameter int IN_W = 8,
    parameter int COEF_W = 9,
    parameter int D = 2,
    parameter int N = 4,
    parameter logic [N*COEF_W-1:0] COEFS = {9'sd10, 9'sd246, 9'sd246, 9'sd10},
    parameter int SHIFT = 0,
    parameter int OUT_W = 18,
    localparam int ACC_W = IN_W + COEF_W + $clog2(N),
    localparam int PH_W = (D > 1) ? $clog2(D) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    sync_clr,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic [PH_W-1:0]         phase
);

    localparam int PROD_W = IN_W + COEF_W;
    localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;

`ifdef ROUND_SAT_EN
    localparam logic signed [EXT_W-1:0] RND =
        (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : EXT_W'(0);
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    function automatic logic signed [COEF_W-1:0] coef(input int k);
        return COEFS[k*COEF_W +: COEF_W];
    endfunction

    function automatic logic signed [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] acc);
`ifdef ROUND_SAT_EN
        logic signed [EXT_W-1:0] v;
        v = (EXT_W'(acc) + RND) >>> SHIFT;
        if (v > SAT_MAX) begin
            post_proc = OUT_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            post_proc = OUT_W'(SAT_MIN);
        end else begin
            post_proc = OUT_W'(v);
        end
`else
        post_proc = OUT_W'(acc >>> SHIFT);
`endif
    endfunction

    logic signed [IN_W-1:0]   x_q [N];
    logic signed [IN_W-1:0]   x_d [N];
    logic signed [PROD_W-1:0] prod_q [N];
    logic signed [PROD_W-1:0] prod_d [N];
    logic [PH_W-1:0]          phase_q, phase_d;
    logic                     fire_q, fire_d;
    logic                     pvld_q;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic signed [ACC_W-1:0]  acc_s;
    logic                     accept_s, dec_s;

    // Stage A next state: delay-line shift, phase advance and fire decision
    always_comb begin
        accept_s = in_valid & ~sync_clr;
        dec_s    = accept_s && (phase_q == PH_W'(D - 1));
        x_d      = x_q;
        phase_d  = phase_q;
        fire_d   = dec_s;
        if (accept_s) begin
            x_d[0] = in_data;
            for (int k = 1; k < N; k++) begin
                x_d[k] = x_q[k-1];
            end
            if (dec_s) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Stage B/C datapath: per-tap products, full-precision sum, output scaling
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < N; k++) begin
            prod_d[k] = PROD_W'(x_q[k]) * PROD_W'(coef(k));
            acc_s     = acc_s + ACC_W'(prod_q[k]);
        end
        out_data_d = post_proc(acc_s);
    end

    // Pipeline registers; a flush drops in-flight results but leaves out_data untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                x_q[k]    <= '0;
                prod_q[k] <= '0;
            end
            phase_q     <= '0;
            fire_q      <= 1'b0;
            pvld_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (sync_clr) begin
            for (int k = 0; k < N; k++) begin
                x_q[k]    <= '0;
                prod_q[k] <= '0;
            end
            phase_q     <= '0;
            fire_q      <= 1'b0;
            pvld_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            phase_q     <= phase_d;
            fire_q      <= fire_d;
            pvld_q      <= fire_q;
            out_valid_q <= pvld_q;
            if (fire_q) begin
                prod_q <= prod_d;
            end
            if (pvld_q) begin
                out_data_q <= out_data_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_polyphase_decim_fir.sv
// Bench for polyphase_decim_fir: four configurations share one stimulus stream and are
// compared every cycle against a sample-history reference model.
module tb_polyphase_decim_fir;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic sync_clr = 1'b0;
    logic signed [7:0] in_data = 8'sd0;

    always #5 clk = ~clk;

`ifdef ROUND_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // h = {-100, 37, 255, -256, 1}, h[0] in LSBs
    localparam logic [44:0] C3 = {9'h001, 9'h100, 9'h0FF, 9'h025, 9'h19C};

    logic ov0, ov1, ov2, ov3;
    logic signed [17:0] od0;
    logic signed [15:0] od1;
    logic signed [17:0] od2;
    logic signed [11:0] od3;
    logic [0:0] ph0, ph1, ph2;
    logic [1:0] ph3;

    polyphase_decim_fir u_dut0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .sync_clr(sync_clr), .out_valid(ov0), .out_data(od0), .phase(ph0));
    polyphase_decim_fir #(.OUT_W(16)) u_dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data(in_data), .sync_clr(sync_clr), .out_valid(ov1), .out_data(od1), .phase(ph1));
    polyphase_decim_fir #(.D(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data(in_data), .sync_clr(sync_clr), .out_valid(ov2), .out_data(od2), .phase(ph2));
    polyphase_decim_fir #(.D(3), .N(5), .COEFS(C3), .SHIFT(4), .OUT_W(12)) u_dut3 (.clk(clk),
        .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .sync_clr(sync_clr),
        .out_valid(ov3), .out_data(od3), .phase(ph3));

    logic   ov_a [4];
    longint od_a [4];
    int     ph_a [4];
    assign ov_a[0] = ov0;  assign ov_a[1] = ov1;  assign ov_a[2] = ov2;  assign ov_a[3] = ov3;
    assign od_a[0] = longint'(od0);  assign od_a[1] = longint'(od1);
    assign od_a[2] = longint'(od2);  assign od_a[3] = longint'(od3);
    assign ph_a[0] = int'(ph0);  assign ph_a[1] = int'(ph1);
    assign ph_a[2] = int'(ph2);  assign ph_a[3] = int'(ph3);

    // Reference model state, one slot per configuration
    int DD [4] = '{2, 2, 1, 3};
    int NN [4] = '{4, 4, 4, 5};
    int OW [4] = '{18, 16, 18, 12};
    int SH [4] = '{0, 0, 0, 4};
    int coef [4][5] = '{'{10, 246, 246, 10, 0}, '{10, 246, 246, 10, 0},
                        '{10, 246, 246, 10, 0}, '{-100, 37, 255, -256, 1}};
    int     hist [4][5];
    int     cnt [4];
    longint last [4];
    bit     eov [4];
    longint pq_val [4][$];
    int     pq_due [4][$];
    longint cap [4][$];
    int     ec;
    int     n_assert;
    int     n_fail;

    function automatic longint post(longint acc, int sh, int ow);
        longint v, mx, mn, m;
        mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (SAT) begin
            if (sh > 0) acc = acc + (64'sd1 <<< (sh - 1));
            v = acc >>> sh;
            if (v > mx) v = mx;
            if (v < mn) v = mn;
        end else begin
            m = (64'sd1 <<< ow) - 64'sd1;
            v = (acc >>> sh) & m;
            if (v > mx) v = v - (64'sd1 <<< ow);
        end
        return v;
    endfunction

    task automatic model_edge(bit v, int d, bit clr);
        longint acc;
        ec++;
        for (int i = 0; i < 4; i++) begin
            eov[i] = 1'b0;
            if (clr) begin
                pq_val[i].delete();
                pq_due[i].delete();
                for (int k = 0; k < 5; k++) hist[i][k] = 0;
                cnt[i] = 0;
            end else begin
                if (pq_due[i].size() > 0 && pq_due[i][0] == ec) begin
                    eov[i]  = 1'b1;
                    last[i] = pq_val[i].pop_front();
                    void'(pq_due[i].pop_front());
                end
                if (v) begin
                    for (int k = NN[i] - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
                    hist[i][0] = d;
                    cnt[i]++;
                    if (cnt[i] == DD[i]) begin
                        cnt[i] = 0;
                        acc = 0;
                        for (int k = 0; k < NN[i]; k++)
                            acc += longint'(coef[i][k]) * longint'(hist[i][k]);
                        pq_val[i].push_back(post(acc, SH[i], OW[i]));
                        pq_due[i].push_back(ec + 2);
                    end
                end
            end
        end
    endtask

    task automatic chk(string tag, longint obs, longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_valid%0d@%0d", i, ec), longint'(ov_a[i]), longint'(eov[i]));
            chk($sformatf("out_data%0d@%0d", i, ec), od_a[i], last[i]);
            chk($sformatf("phase%0d@%0d", i, ec), longint'(ph_a[i]), longint'(cnt[i]));
            if (ov_a[i] === 1'b1) cap[i].push_back(od_a[i]);
        end
    endtask

    task automatic step(bit v, logic signed [7:0] d, bit clr);
        in_valid = v;
        in_data  = d;
        sync_clr = clr;
        @(posedge clk);
        model_edge(v, int'(d), clr);
        #1;
        check_all();
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 4; i++) cap[i].delete();
    endtask

    task automatic expect_cap(int i, string tag, longint e[$]);
        longint o;
        chk({tag, "_count"}, longint'(cap[i].size()), longint'(e.size()));
        foreach (e[k]) begin
            o = (k < cap[i].size()) ? cap[i][k] : -64'sd999999;
            chk($sformatf("%s_%0d", tag, k), o, e[k]);
        end
    endtask

    task automatic impulse();
        step(1'b1, 8'sd1, 1'b0);
        repeat (5) step(1'b1, 8'sd0, 1'b0);
        repeat (4) step(1'b0, 8'sd0, 1'b0);
    endtask

    task automatic mid_reset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'sd55;
        #1;
        for (int i = 0; i < 4; i++) begin
            pq_val[i].delete();
            pq_due[i].delete();
            for (int k = 0; k < 5; k++) hist[i][k] = 0;
            cnt[i]  = 0;
            last[i] = 0;
            eov[i]  = 1'b0;
        end
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
        step(1'b0, 8'sd0, 1'b0);
    endtask

    initial begin
        longint e[$];
        logic signed [7:0] rd;
        n_assert = 0;
        n_fail   = 0;
        ec       = 0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_all();
        #10 rst_n = 1'b1;

        // Impulse
        clear_cap();
        impulse();
        e = '{246, 10, 0};
        expect_cap(0, "impulse", e);
        expect_cap(1, "impulse_w16", e);
        e = '{10, 246, 246, 10, 0, 0};
        expect_cap(2, "impulse_d1", e);

        // Step +127, including overflow of the 16-bit output
        clear_cap();
        repeat (8) step(1'b1, 8'sd127, 1'b0);
        repeat (4) step(1'b0, 8'sd0, 1'b0);
        e = '{32512, 65024, 65024, 65024};
        expect_cap(0, "step_pos", e);
        if (SAT) e = '{32512, 32767, 32767, 32767};
        else     e = '{32512, -512, -512, -512};
        expect_cap(1, "step_pos_w16", e);

        // Flush, then step -128
        step(1'b0, 8'sd0, 1'b1);
        clear_cap();
        repeat (8) step(1'b1, -8'sd128, 1'b0);
        repeat (4) step(1'b0, 8'sd0, 1'b0);
        e = '{-32768, -65536, -65536, -65536};
        expect_cap(0, "step_neg", e);

        // Gapped impulse: idle cycles carry junk data that must be ignored
        step(1'b0, 8'sd0, 1'b1);
        clear_cap();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, (k == 0) ? 8'sd1 : 8'sd0, 1'b0);
            rd = 8'($urandom);
            step(1'b0, rd, 1'b0);
        end
        repeat (4) step(1'b0, 8'sd0, 1'b0);
        e = '{246, 10, 0};
        expect_cap(0, "gapped", e);

        // Flush one cycle after a decimating sample suppresses that result
        step(1'b0, 8'sd0, 1'b1);
        clear_cap();
        step(1'b1, 8'sd5, 1'b0);
        step(1'b1, 8'sd7, 1'b0);
        step(1'b1, 8'sd9, 1'b1);
        repeat (4) step(1'b0, 8'sd0, 1'b0);
        e = '{};
        expect_cap(0, "flush_drop", e);
        clear_cap();
        impulse();
        e = '{246, 10, 0};
        expect_cap(0, "flush_impulse", e);

        // Random traffic with occasional flushes
        repeat (300) begin
            rd = 8'($urandom);
            step(($urandom % 4) != 0, rd, ($urandom % 50) == 0);
        end

        // Reset mid-frame, then a clean impulse
        step(1'b1, 8'sd3, 1'b0);
        mid_reset();
        clear_cap();
        impulse();
        e = '{246, 10, 0};
        expect_cap(0, "reset_impulse", e);

        repeat (100) begin
            rd = 8'($urandom);
            step(($urandom % 3) != 0, rd, ($urandom % 60) == 0);
        end
        repeat (4) step(1'b0, 8'sd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
